// File: rtl/cl_serial_ctrl.sv
// cl_serial_ctrl: bit-serial sequencer for the shared 1-bit logic cell `cl`.
//
// Accepts two WIDTH-bit operands and a 2-bit op through a start/done handshake.
// It presents one bit pair per clock to the cell, LSB first, and assembles the
// cell's answers into a WIDTH-bit result.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   request strobe, sampled only in IDLE
//   op        in   [1:0] 00 AND, 01 OR, 10 XOR, 11 NOT a
//   a_in      in   [WIDTH-1:0] operand A, captured on the accepting edge
//   b_in      in   [WIDTH-1:0] operand B, captured on the accepting edge
//   cell_a    out  current bit of A to the cell (0 outside RUN)
//   cell_b    out  current bit of B to the cell (0 outside RUN)
//   cell_s    out  [1:0] select to the cell (0 outside RUN)
//   cell_out  in   combinational cell result for cell_a/cell_b/cell_s
//   busy      out  high while the operation is running
//   done      out  one-cycle pulse when result is valid
//   result    out  [WIDTH-1:0] assembled result, held until the next completion
//   zero      out  result == 0, updated together with result

module cl_serial_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cell_a,
    output logic             cell_b,
    output logic [1:0]       cell_s,
    input  logic             cell_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_sh;
    logic [WIDTH-1:0] sh_next;
    logic             running;

    // Cell answers enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign sh_next = {cell_out, result_sh[WIDTH-1:1]};
    assign running = (state == RUN);

    // The cell is combinational, so its inputs must follow the live shift
    // registers within the same cycle; gate them to 0 outside RUN.
    assign cell_a = running & a_reg[0];
    assign cell_b = running & b_reg[0];
    assign cell_s = running ? op_reg : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 2'b00;
            cnt       <= '0;
            result_sh <= '0;
            result    <= '0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        op_reg    <= op;
                        cnt       <= '0;
                        result_sh <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result_sh <= sh_next;
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result <= sh_next;
                        zero   <= (sh_next == '0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // Start is not looked at here; no request queuing.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
